mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 12 +
 rtl/mem_arbiter_if.sv | 25 ++
 rtl/mem_arbiter_rr_arb2.sv | 14 +
 rtl/mem_arbiter.sv | 103 ++++++++++
 tb/tb_mem_arbiter.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and default widths for the two-port SRAM arbiter.
// The FSM state is exported so checkers can watch it.
package mem_arb_pkg;
    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_e;
endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side bus of the SRAM arbiter: two requesters share one set of wires.
// Handshake: bit i of a request is taken at a rising edge where req_valid[i] & req_ready[i];
// the requester holds valid/we/addr/wdata stable until then, and rsp_valid[i] pulses one cycle on completion.
interface mem_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
);
    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [1:0]          req_we;
    logic [2*ADDR_W-1:0] req_addr;
    logic [2*DATA_W-1:0] req_wdata;
    logic [1:0]          rsp_valid;
    logic [DATA_W-1:0]   rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the one
// that did not win last time. Purely combinational; grant is one-hot or zero.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);
    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = last ? 2'b01 : 2'b10;
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates two requesters onto one asynchronous-style SRAM with a shared
// tristate data bus. Each access is one cycle, followed by a one-cycle response.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_arbiter_if.slave      bus,
    output logic              mem_cs,
    output logic              mem_we,
    output logic              mem_oe,
    output logic [ADDR_W-1:0] mem_addr,
    inout  wire  [DATA_W-1:0] mem_data,
    output state_e            dbg_state
);
    state_e            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [1:0]        rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        grant;
    logic [1:0]        req_ready_c;

    rr_arb2 u_rr_arb2 (
        .req   (bus.req_valid),
        .last  (last_grant_q),
        .grant (grant)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rsp_valid_q  <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rsp_valid_q  <= rsp_valid_d;
            rdata_q      <= rdata_d;
        end
    end

    // The registered write/read direction lives in the state itself (WRITE vs READ).
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rsp_valid_d  = '0;
        rdata_d      = rdata_q;
        req_ready_c  = '0;
        case (state_q)
            IDLE: begin
                // ready is masked by rst_n so nothing looks accepted while reset is held
                req_ready_c = rst_n ? grant : 2'b00;
                if ((bus.req_valid & req_ready_c) != 2'b00) begin
                    owner_d      = grant[1];
                    last_grant_d = grant[1];
                    addr_d       = grant[1] ? bus.req_addr[2*ADDR_W-1 -: ADDR_W]
                                            : bus.req_addr[ADDR_W-1:0];
                    wdata_d      = grant[1] ? bus.req_wdata[2*DATA_W-1 -: DATA_W]
                                            : bus.req_wdata[DATA_W-1:0];
                    state_d      = bus.req_we[grant[1]] ? WRITE : READ;
                end
            end
            WRITE: begin
                state_d              = IDLE;
                rsp_valid_d[owner_q] = 1'b1;
            end
            READ: begin
                state_d              = IDLE;
                rsp_valid_d[owner_q] = 1'b1;
                rdata_d              = mem_data;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.req_ready = req_ready_c;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rdata_q;

    assign mem_cs    = (state_q != IDLE);
    assign mem_we    = (state_q == WRITE);
    assign mem_oe    = (state_q == READ);
    assign mem_addr  = addr_q;
    // Only WRITE drives the bus, so the SRAM output never fights the controller.
    assign mem_data  = (state_q == WRITE) ? wdata_q : {DATA_W{1'bz}};
    assign dbg_state = state_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a 4K x 8 SRAM model on the shared bus.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 12;
  localparam int DW = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  logic          mem_cs;
  logic          mem_we;
  logic          mem_oe;
  logic [AW-1:0] mem_addr;
  wire  [DW-1:0] mem_data;
  state_e        dbg_state;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .mem_cs    (mem_cs),
    .mem_we    (mem_we),
    .mem_oe    (mem_oe),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .dbg_state (dbg_state)
  );

  // ---------------- SRAM model ----------------
  logic [DW-1:0] sram [0:4095];
  logic [DW-1:0] sram_dout;
  logic          sram_drive;
  assign sram_drive = mem_cs & mem_oe & ~mem_we;
  assign mem_data = sram_drive ? sram_dout : {DW{1'bz}};
  always @(posedge clk) if (mem_cs && mem_we) sram[mem_addr] <= mem_data;
  always @(negedge clk) if (mem_cs && mem_oe) sram_dout <= sram[mem_addr];

  // ---------------- scoreboard state ----------------
  int            tests_run = 0;
  int            tests_failed = 0;
  int            bus_viol = 0;
  logic [DW-1:0] last_rd = '0;
  longint        acc_time = 0;
  logic [DW-1:0] exp_q[$];

  always @(negedge clk) begin
    if (rst_n) begin
      if (dbg_state == IDLE && (mem_cs || mem_we || mem_oe)) bus_viol++;
      if (mem_cs && mem_we && sram_drive) bus_viol++;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic launch(input int m, input bit we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, output bit ok);
    ok = 1'b0;
    bus.req_we[m] = we;
    bus.req_addr[m*AW +: AW] = a;
    bus.req_wdata[m*DW +: DW] = d;
    bus.req_valid[m] = 1'b1;
    for (int n = 0; n < 40; n++) begin
      #1;
      if (bus.req_ready[m]) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) begin
      @(posedge clk);
      acc_time = $time;
      #1;
    end else begin
      check("accept_timeout", 32'd0, 32'd1);
    end
    bus.req_valid[m] = 1'b0;
  endtask

  // For reads, d is the expected read data.
  task automatic single(input int m, input bit we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input string tag);
    bit ok;
    launch(m, we, a, d, ok);
    if (ok) begin
      @(negedge clk);
      check({tag, "_cs"}, 32'(mem_cs), 32'd1);
      check({tag, "_addr"}, 32'(mem_addr), 32'(a));
      if (we) check({tag, "_busdata"}, 32'(mem_data), 32'(d));
      @(negedge clk);
      check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'(2'b01 << m));
      if (!we) begin
        check({tag, "_rdata"}, 32'(bus.rsp_rdata), 32'(d));
        last_rd = d;
      end else begin
        check({tag, "_rdata_hold"}, 32'(bus.rsp_rdata), 32'(last_rd));
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit     ok;
    int     got;
    longint prev;
    logic [DW-1:0] d;

    bus.req_valid = 2'b11;
    bus.req_we    = 2'b00;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(bus.req_ready), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rdata", 32'(bus.rsp_rdata), 32'd0);
    check("rst_cs_we_oe", 32'({mem_cs, mem_we, mem_oe}), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    bus.req_valid = 2'b00;
    rst_n = 1'b1;

    // Tie after reset: m0 first, then strict alternation while both stay valid.
    bus.req_we    = 2'b11;
    bus.req_addr  = {12'h020, 12'h010};
    bus.req_wdata = {8'hB0, 8'hA0};
    bus.req_valid = 2'b11;
    got = 0;
    for (int n = 0; n < 30 && got < 4; n++) begin
      #1;
      if (bus.req_ready != 2'b00) begin
        check("grant_order", 32'(bus.req_ready), (got % 2 == 0) ? 32'd1 : 32'd2);
        got++;
      end
      @(negedge clk);
    end
    bus.req_valid = 2'b00;
    if (got < 4) check("grant_timeout", 32'(got), 32'd4);
    repeat (3) @(negedge clk);
    single(0, 1'b0, 12'h010, 8'hA0, "tie_rd_m0");
    single(1, 1'b0, 12'h020, 8'hB0, "tie_rd_m1");

    // Single write then read, then a write that must not disturb rsp_rdata.
    single(0, 1'b1, 12'h0A5, 8'h3C, "wr_0a5");
    single(0, 1'b0, 12'h0A5, 8'h3C, "rd_0a5");
    single(0, 1'b1, 12'h0B0, 8'h55, "wr_0b0");

    // Address extremes must not alias.
    single(1, 1'b1, 12'hFFF, 8'hEE, "wr_fff");
    single(1, 1'b1, 12'h000, 8'h11, "wr_000");
    single(0, 1'b0, 12'hFFF, 8'hEE, "rd_fff");
    single(0, 1'b0, 12'h000, 8'h11, "rd_000");

    // Reset in the middle of a READ.
    launch(0, 1'b0, 12'h0A5, 8'h00, ok);
    @(negedge clk);
    check("midrst_in_read", 32'(mem_oe), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_cs_we_oe", 32'({mem_cs, mem_we, mem_oe}), 32'd0);
    check("midrst_addr", 32'(mem_addr), 32'd0);
    check("midrst_rdata", 32'(bus.rsp_rdata), 32'd0);
    check("midrst_ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    check("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    rst_n = 1'b1;
    last_rd = '0;
    @(negedge clk);
    check("postrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    single(0, 1'b0, 12'h0A5, 8'h3C, "rd_after_rst");

    // Back-to-back from m1: each launched in its own rsp_valid cycle.
    prev = 0;
    for (int i = 0; i < 8; i++) begin
      d = 8'(i * 29 + 7);
      exp_q.push_back(d);
      single(1, 1'b1, 12'h300 + 12'(i), d, "b2b_wr");
      if (i > 0) check("b2b_wr_gap", 32'(acc_time - prev), 32'd20);
      prev = acc_time;
    end
    for (int i = 0; i < 8; i++) begin
      d = exp_q.pop_front();
      single(1, 1'b0, 12'h300 + 12'(i), d, "b2b_rd");
      check("b2b_rd_gap", 32'(acc_time - prev), 32'd20);
      prev = acc_time;
    end

    repeat (2) @(negedge clk);
    check("bus_discipline", 32'(bus_viol), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests_run);
    $fatal(1);
  end
endmodule
